// File: rtl/yuv_block_writer.sv
// Clips 8x8 IDCT sample blocks to bytes, packs pixel pairs into 16-bit words and
// writes a full Y, U, V frame into the SRAM segments read by the colourspace stage.
module yuv_block_writer #(
  parameter logic [17:0] Y_BASE        = 18'd0,
  parameter logic [17:0] U_BASE        = 18'd38400,
  parameter logic [17:0] V_BASE        = 18'd57600,
  parameter int          Y_BLOCK_COLS  = 40,
  parameter int          UV_BLOCK_COLS = 20,
  parameter int          BLOCK_ROWS    = 30
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic        Finish,
  input  logic        Sample_valid,
  output logic        Sample_ready,
  input  logic [31:0] Sample_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_FINISH} state_t;
  typedef enum logic [1:0] {SEG_Y, SEG_U, SEG_V} seg_t;

  localparam logic [17:0] Y_WPR       = 18'(4 * Y_BLOCK_COLS);
  localparam logic [17:0] UV_WPR      = 18'(4 * UV_BLOCK_COLS);
  localparam logic [7:0]  Y_LAST_COL  = 8'(Y_BLOCK_COLS - 1);
  localparam logic [7:0]  UV_LAST_COL = 8'(UV_BLOCK_COLS - 1);
  localparam logic [7:0]  LAST_ROW    = 8'(BLOCK_ROWS - 1);

  state_t      state, next_state;
  seg_t        seg;
  logic [7:0]  block_row, block_col;
  logic [2:0]  row, col;
  logic [7:0]  held;

  logic [17:0] seg_base, wpr, line, word_addr;
  logic [7:0]  last_col, clipped;
  logic        accept, last_sample;

  assign accept = Sample_valid && Sample_ready;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    seg_base = V_BASE;
    wpr      = UV_WPR;
    last_col = UV_LAST_COL;
    case (seg)
      SEG_Y: begin
        seg_base = Y_BASE;
        wpr      = Y_WPR;
        last_col = Y_LAST_COL;
      end
      SEG_U: seg_base = U_BASE;
      default: ;
    endcase

    // 8*block_row + row is simply the concatenation of the two counters.
    line      = 18'({block_row, row});
    word_addr = seg_base + line * wpr + {8'd0, block_col, 2'b00} + {16'd0, col[2:1]};

    if (Sample_data[31])          clipped = 8'd0;
    else if (|Sample_data[30:8])  clipped = 8'hFF;
    else                          clipped = Sample_data[7:0];

    last_sample = (seg == SEG_V) && (block_row == LAST_ROW) && (block_col == UV_LAST_COL)
                  && (row == 3'd7) && (col == 3'd7);
  end

  always_comb begin
    next_state   = state;
    Sample_ready = 1'b0;
    case (state)
      S_IDLE:   if (Start) next_state = S_ACCEPT;
      S_ACCEPT: begin
        Sample_ready = 1'b1;
        if (accept && last_sample) next_state = S_FINISH;
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: the held byte is a plain register, not a memory, so it is reset
  // along with everything else; a reset drops any half-built pixel pair.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
      SRAM_we_n       <= 1'b1;
      Finish          <= 1'b0;
      seg             <= SEG_Y;
      block_row       <= '0;
      block_col       <= '0;
      row             <= '0;
      col             <= '0;
      held            <= '0;
    end else begin
      SRAM_we_n <= 1'b1;
      Finish    <= (state == S_FINISH);

      if (state == S_IDLE && Start) begin
        seg       <= SEG_Y;
        block_row <= '0;
        block_col <= '0;
        row       <= '0;
        col       <= '0;
      end

      if (accept) begin
        if (!col[0]) begin
          held <= clipped;
        end else begin
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= word_addr;
          SRAM_write_data <= {held, clipped};
        end

        // The final sample wraps every counter back to zero for the next frame.
        col <= col + 3'd1;
        if (col == 3'd7) begin
          row <= row + 3'd1;
          if (row == 3'd7) begin
            if (block_col == last_col) begin
              block_col <= '0;
              if (block_row == LAST_ROW) begin
                block_row <= '0;
                case (seg)
                  SEG_Y:   seg <= SEG_U;
                  SEG_U:   seg <= SEG_V;
                  default: seg <= SEG_Y;
                endcase
              end else begin
                block_row <= block_row + 8'd1;
              end
            end else begin
              block_col <= block_col + 8'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_yuv_block_writer.sv
// Directed bench for yuv_block_writer on a reduced frame geometry (4x2 Y blocks,
// 2x2 U/V blocks, non-contiguous segment bases) so whole frames stay short.
module tb_yuv_block_writer;

  localparam logic [17:0] YB = 18'd0;
  localparam logic [17:0] UB = 18'd1000;
  localparam logic [17:0] VB = 18'd2000;
  localparam int YC = 4;
  localparam int UC = 2;
  localparam int BR = 2;
  localparam int FRAME_SAMPLES = 1024;
  localparam int FRAME_WORDS   = 512;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Finish;
  logic        Sample_valid = 1'b0;
  logic        Sample_ready;
  logic [31:0] Sample_data = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  yuv_block_writer #(
    .Y_BASE(YB), .U_BASE(UB), .V_BASE(VB),
    .Y_BLOCK_COLS(YC), .UV_BLOCK_COLS(UC), .BLOCK_ROWS(BR)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Finish(Finish),
    .Sample_valid(Sample_valid), .Sample_ready(Sample_ready), .Sample_data(Sample_data),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n)
  );

  always #10 Clock = ~Clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  logic [31:0] stim [0:FRAME_SAMPLES-1];

  // SRAM image and write log captured on the falling edge.
  logic [15:0] sram [int];
  logic [17:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [17:0] ref_addr_q[$];
  logic [15:0] ref_data_q[$];
  int wr_cnt = 0, last_wr_cyc = 0, finish_cyc = 0, finish_cnt = 0, b2b = 0;
  bit prev_we = 1'b0;

  always @(negedge Clock) begin
    if (!SRAM_we_n) begin
      sram[int'(SRAM_address)] = SRAM_write_data;
      wr_addr_q.push_back(SRAM_address);
      wr_data_q.push_back(SRAM_write_data);
      wr_cnt++;
      last_wr_cyc = cyc;
      if (prev_we) b2b++;
    end
    prev_we = !SRAM_we_n;
    if (Finish) begin
      finish_cnt++;
      finish_cyc = cyc;
    end
  end

  task automatic clear_capture();
    sram.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cnt = 0; finish_cnt = 0; b2b = 0;
  endtask

  task automatic pulse_start();
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
  endtask

  // Feeds stim[first .. first+n-1]; gap_pct drops Sample_valid at random,
  // stray_start pulses Start at random while the frame is in progress.
  task automatic feed(input int first, input int n, input int gap_pct, input bit stray_start);
    int idx = 0;
    int budget = 0;
    while (idx < n && budget < 20000) begin
      @(negedge Clock);
      budget++;
      Start = stray_start && ($urandom_range(0, 49) == 0);
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        Sample_valid = 1'b0;
        Sample_data  = 32'hDEAD_BEEF;
      end else begin
        Sample_valid = 1'b1;
        Sample_data  = stim[first + idx];
        if (Sample_ready) idx++;
      end
    end
    @(negedge Clock);
    Sample_valid = 1'b0;
    Start = 1'b0;
    total++;
    if (idx < n) begin
      bad++;
      $display("FAIL feed_timeout accepted=%0d wanted=%0d", idx, n);
    end
  endtask

  task automatic wait_finish();
    int k = 0;
    while (finish_cnt == 0 && k < 20) begin
      @(negedge Clock);
      k++;
    end
    total++;
    if (finish_cnt == 0) begin
      bad++;
      $display("FAIL finish_timeout no Finish pulse within %0d cycles", k);
    end
    repeat (3) @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    total++;
    if ({SRAM_we_n, Sample_ready, Finish} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl we_n/ready/finish got=%b exp=100", {SRAM_we_n, Sample_ready, Finish});
    end
    total++;
    if (SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0) begin
      bad++;
      $display("FAIL reset_bus got addr=%0d data=%h exp addr=0 data=0000", SRAM_address, SRAM_write_data);
    end
    Reset = 1'b0;
  endtask

  task automatic test_idle_ignore();
    int ready_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (Sample_ready) ready_seen++;
      Sample_valid = 1'b1;
      Sample_data  = 32'h0000_0055;
    end
    @(negedge Clock);
    Sample_valid = 1'b0;
    repeat (2) @(negedge Clock);
    total++;
    if (ready_seen != 0 || wr_cnt != 0) begin
      bad++;
      $display("FAIL idle_ignore got ready_cycles=%0d writes=%0d exp 0 and 0", ready_seen, wr_cnt);
    end
  endtask

  task automatic test_full_frame();
    int a_tab[13] = '{0, 1, 2, 3, 16, 115, 4, 128, 255, 1000, 1064, 2000, 2127};
    logic [15:0] d_tab[13] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809, 16'h3E3F,
                               16'h4041, 16'h0001, 16'hFEFF, 16'h0001, 16'h8081, 16'h0001,
                               16'hFEFF};
    int j = 0;
    int seq_err = 0;
    logic [17:0] base;
    int wpr, cols;
    logic [15:0] got;

    clear_capture();
    for (int k = 0; k < FRAME_SAMPLES; k++) stim[k] = 32'(k % 256);
    pulse_start();
    feed(0, FRAME_SAMPLES, 0, 1'b0);
    wait_finish();

    for (int i = 0; i < 13; i++) begin
      got = sram.exists(a_tab[i]) ? sram[a_tab[i]] : 16'hxxxx;
      total++;
      if (got !== d_tab[i]) begin
        bad++;
        $display("FAIL frame_word addr=%0d got=%h exp=%h", a_tab[i], got, d_tab[i]);
      end
    end

    // Independent model of the write order: segment, block row/col, row, word.
    for (int s = 0; s < 3; s++) begin
      base = (s == 0) ? YB : (s == 1) ? UB : VB;
      cols = (s == 0) ? YC : UC;
      wpr  = 4 * cols;
      for (int br = 0; br < BR; br++)
        for (int bc = 0; bc < cols; bc++)
          for (int r = 0; r < 8; r++)
            for (int w = 0; w < 4; w++) begin
              if (j >= wr_addr_q.size() ||
                  wr_addr_q[j] !== base + 18'((8 * br + r) * wpr + 4 * bc + w) ||
                  wr_data_q[j] !== {8'((2 * j) % 256), 8'((2 * j + 1) % 256)})
                seq_err++;
              j++;
            end
    end
    total++;
    if (seq_err != 0 || wr_cnt != FRAME_WORDS) begin
      bad++;
      $display("FAIL frame_sequence got mismatches=%0d writes=%0d exp 0 and %0d", seq_err, wr_cnt, FRAME_WORDS);
    end

    total++;
    if (finish_cnt != 1 || finish_cyc != last_wr_cyc + 1) begin
      bad++;
      $display("FAIL finish_timing got pulses=%0d at cycle %0d exp 1 at %0d", finish_cnt, finish_cyc, last_wr_cyc + 1);
    end
    total++;
    if (Sample_ready !== 1'b0 || b2b != 0) begin
      bad++;
      $display("FAIL after_finish got ready=%b back_to_back=%0d exp 0 and 0", Sample_ready, b2b);
    end

    ref_addr_q = wr_addr_q;
    ref_data_q = wr_data_q;
  endtask

  task automatic test_back_to_back();
    int diff = 0;
    clear_capture();
    pulse_start();
    feed(0, FRAME_SAMPLES, 35, 1'b1);
    wait_finish();
    total++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] !== 18'd0) begin
      bad++;
      $display("FAIL restart_addr got first addr=%0d exp=0", wr_addr_q.size() ? wr_addr_q[0] : 18'h3FFFF);
    end
    for (int i = 0; i < ref_addr_q.size(); i++)
      if (i >= wr_addr_q.size() || wr_addr_q[i] !== ref_addr_q[i] || wr_data_q[i] !== ref_data_q[i])
        diff++;
    total++;
    if (diff != 0 || wr_addr_q.size() != ref_addr_q.size()) begin
      bad++;
      $display("FAIL gapped_sequence got diffs=%0d writes=%0d exp 0 and %0d", diff, wr_addr_q.size(), ref_addr_q.size());
    end
    total++;
    if (finish_cnt != 1 || b2b != 0) begin
      bad++;
      $display("FAIL gapped_finish got pulses=%0d back_to_back=%0d exp 1 and 0", finish_cnt, b2b);
    end
  endtask

  task automatic test_clip_and_reset();
    int a_tab[4] = '{0, 1, 2, 3};
    logic [15:0] d_tab[4] = '{16'h00FF, 16'hFFFF, 16'h00FF, 16'h8000};
    logic [15:0] got;
    int writes_before;

    clear_capture();
    stim[0] = -32'sd5;        stim[1] = 32'd300;
    stim[2] = 32'd255;        stim[3] = 32'd256;
    stim[4] = 32'h8000_0000;  stim[5] = 32'h0001_0000;
    stim[6] = 32'd128;        stim[7] = 32'hFFFF_FFFF;
    stim[8] = 32'h0000_0077;
    pulse_start();
    feed(0, 8, 0, 1'b0);
    repeat (2) @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      got = sram.exists(a_tab[i]) ? sram[a_tab[i]] : 16'hxxxx;
      total++;
      if (got !== d_tab[i]) begin
        bad++;
        $display("FAIL clip addr=%0d got=%h exp=%h", a_tab[i], got, d_tab[i]);
      end
    end

    // Leave an even sample held, then reset for two cycles mid-frame.
    feed(8, 1, 0, 1'b0);
    writes_before = wr_cnt;
    @(negedge Clock); Reset = 1'b1;
    @(negedge Clock);
    total++;
    if ({SRAM_we_n, Sample_ready, Finish} !== 3'b100 || SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset got we_n/ready/finish=%b addr=%0d data=%h exp 100 0 0000",
               {SRAM_we_n, Sample_ready, Finish}, SRAM_address, SRAM_write_data);
    end
    @(negedge Clock); Reset = 1'b0;
    repeat (2) @(negedge Clock);
    total++;
    if (wr_cnt != writes_before || Sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_write got writes=%0d ready=%b exp %0d and 0", wr_cnt, Sample_ready, writes_before);
    end

    clear_capture();
    stim[0] = 32'h12; stim[1] = 32'h34;
    pulse_start();
    feed(0, 2, 0, 1'b0);
    repeat (2) @(negedge Clock);
    total++;
    if (wr_cnt != 1 || wr_addr_q.size() == 0 || wr_addr_q[0] !== 18'd0 || wr_data_q[0] !== 16'h1234) begin
      bad++;
      $display("FAIL post_reset_word got writes=%0d addr=%0d data=%h exp 1 0 1234", wr_cnt,
               wr_addr_q.size() ? wr_addr_q[0] : 18'h3FFFF, wr_data_q.size() ? wr_data_q[0] : 16'hxxxx);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_frame();
    test_back_to_back();
    test_clip_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
